// File: rtl/d_sramlike_adapter_pkg.sv
// -----------------------------------------------------------------------------
// d_sramlike_adapter_pkg
// Shared defines for the data-side sram-like adapter: the 2-bit FSM state
// encoding and the access-size codes used on data_sram_size / data_size.
// No ports (package).
// -----------------------------------------------------------------------------
package d_sramlike_adapter_pkg;

  // One transaction walks IDLE -> ADDR -> DATA -> DONE -> IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } AdapterState;

  // Access-size codes shared by the core side and the sram-like side.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/d_sramlike_adapter.sv
// -----------------------------------------------------------------------------
// d_sramlike_adapter
// Bridges the core's single-cycle data-SRAM port onto a split sram-like
// request/response channel. The core is held with d_stall while one access
// is in flight; the returned load data is registered for the M stage.
//
// Ports
//   clk              core clock, rising edge
//   rst              asynchronous active-low reset
//   data_sram_en     M-stage access request
//   data_sram_wen    byte write strobes, 0 = read
//   data_sram_size   access size (byte/half/word)
//   data_sram_addr   byte address
//   data_sram_wdata  lane-aligned store data
//   data_sram_rdata  registered load data back to the core
//   longest_stall    pipeline-wide stall from the hazard unit
//   d_stall          stall request to the hazard unit
//   data_req/wr/size/addr/wdata   sram-like request channel
//   data_addr_ok/data_data_ok/data_rdata   sram-like responses
// -----------------------------------------------------------------------------
import d_sramlike_adapter_pkg::*;

module d_sramlike_adapter (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        longest_stall,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  AdapterState state;
  AdapterState nextState;

  logic        reqWr;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [31:0] rdataReg;

  logic        startAccess;
  logic        finishAccess;
  logic        busyStall;
  logic        reqActive;

  // Next-state and strobe decode. Handshakes are only looked at in the one
  // state that is waiting for them, so stray pulses elsewhere are harmless.
  // Dropping data_sram_en after IDLE does not abort: a flushed instruction
  // still has to see its bus access complete.
  always_comb begin
    nextState    = state;
    startAccess  = 1'b0;
    finishAccess = 1'b0;
    busyStall    = 1'b0;
    reqActive    = 1'b0;
    case (state)
      IDLE: begin
        if (data_sram_en) begin
          startAccess = 1'b1;
          busyStall   = 1'b1;
          nextState   = ADDR;
        end
      end
      ADDR: begin
        reqActive = 1'b1;
        busyStall = 1'b1;
        if (data_addr_ok) begin
          nextState = DATA;
        end
      end
      DATA: begin
        busyStall = 1'b1;
        if (data_data_ok) begin
          finishAccess = 1'b1;
          nextState    = DONE;
        end
      end
      DONE: begin
        // Parked here so a frozen pipeline does not re-issue the same access.
        if (!longest_stall) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Request fields are captured once on acceptance so the sram-like side
  // sees them stable for the whole transaction, whatever the core does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqWr    <= 1'b0;
      reqSize  <= SIZE_BYTE;
      reqAddr  <= 32'd0;
      reqWdata <= 32'd0;
    end else if (startAccess) begin
      reqWr    <= |data_sram_wen;
      reqSize  <= data_sram_size;
      reqAddr  <= data_sram_addr;
      reqWdata <= data_sram_wdata;
    end
  end

  // Load data register; stores leave the previous load value untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdataReg <= 32'd0;
    end else if (finishAccess && !reqWr) begin
      rdataReg <= data_rdata;
    end
  end

  assign data_req        = reqActive;
  assign data_wr         = reqWr;
  assign data_size       = reqSize;
  assign data_addr       = reqAddr;
  assign data_wdata      = reqWdata;
  assign data_sram_rdata = rdataReg;

  // Reset gates the stall so an asserted enable during reset cannot freeze
  // the pipeline.
  assign d_stall = rst & busyStall;

endmodule
